seq_restoring_divider: RTL and testbench

//  Parametrised multi-cycle restoring divider. Next generation of the fixed 4-bit shift/compare-subtract divider.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 22 ++
 rtl/seq_restoring_divider.sv | 129 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Helpers work on 64-bit values; callers cast the result back to their width.
package div_pkg;

   typedef enum logic [2:0] {IDLE, ITER, FIX, DONE, ZERO} state_e;

   // Smallest width that can hold the value n (i.e. clog2(n+1)).
   function automatic int cnt_w(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n + 1) w = i + 1;
      return w;
   endfunction

   function automatic logic [63:0] neg(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction

   // Two's-complement magnitude of a w-bit value held in the low bits of v.
   // abs(MIN) comes out as 2^(w-1), which still fits as an unsigned w-bit value.
   function automatic logic [63:0] abs_val(input logic [63:0] v, input int w);
      return v[w-1] ? neg(v) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
   parameter int WL = 8
) (
   input  logic [WL-1:0] i_rh,
   input  logic          i_bit,
   input  logic [WL-1:0] i_d,
   output logic [WL-1:0] o_rh,
   output logic          o_q
);

   // The shifted partial remainder needs one extra bit so the compare cannot wrap.
   logic [WL:0]   w_sh;
   logic [WL-1:0] w_diff;

   assign w_sh   = {i_rh, i_bit};
   assign o_q    = (w_sh >= {1'b0, i_d});
   // When the subtraction is taken the true result is below d, so WL bits suffice.
   assign w_diff = w_sh[WL-1:0] - i_d;
   assign o_rh   = o_q ? w_diff : w_sh[WL-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider with signed/unsigned mode, start/ready/done handshake,
// divide-by-zero and signed-overflow flags. One operation in flight at a time.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int WL        = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic          signed_mode,
   input  logic [WL-1:0] dividend,
   input  logic [WL-1:0] divisor,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic [WL-1:0] quotient,
   output logic [WL-1:0] remainder,
   output logic          div_by_zero,
   output logic          overflow
);

   localparam int CW = cnt_w(WL);

   state_e        r_state;
   logic [CW-1:0] r_cnt;
   logic [WL-1:0] r_rh, r_rl, r_d, r_dvd;
   logic          r_neg_q, r_neg_r, r_ovf;
   logic          r_ready, r_done, r_dbz, r_ov;
   logic [WL-1:0] r_q, r_r;

   logic          w_sgn;
   logic [WL-1:0] w_abs_n, w_abs_d, w_rh_nxt, w_q_fix, w_r_fix;
   logic          w_qbit;

   assign w_sgn   = SIGNED_EN && signed_mode;
   assign w_abs_n = w_sgn ? WL'(abs_val(64'(dividend), WL)) : dividend;
   assign w_abs_d = w_sgn ? WL'(abs_val(64'(divisor), WL))  : divisor;
   // Truncating division: quotient sign from the operand signs, remainder follows the dividend.
   assign w_q_fix = r_neg_q ? WL'(neg(64'(r_rl))) : r_rl;
   assign w_r_fix = r_neg_r ? WL'(neg(64'(r_rh))) : r_rh;

   div_step #(.WL(WL)) u_step (
      .i_rh  (r_rh),
      .i_bit (r_rl[WL-1]),
      .i_d   (r_d),
      .o_rh  (w_rh_nxt),
      .o_q   (w_qbit)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rh    <= '0;
         r_rl    <= '0;
         r_d     <= '0;
         r_dvd   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_ovf   <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_q     <= '0;
         r_r     <= '0;
         r_dbz   <= 1'b0;
         r_ov    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_dvd   <= dividend;
                  r_d     <= w_abs_d;
                  r_rl    <= w_abs_n;
                  r_rh    <= '0;
                  r_cnt   <= CW'(WL);
                  r_neg_q <= w_sgn && (dividend[WL-1] ^ divisor[WL-1]);
                  r_neg_r <= w_sgn && dividend[WL-1];
                  r_ovf   <= w_sgn && (dividend == {1'b1, {(WL-1){1'b0}}}) && (&divisor);
                  r_ready <= 1'b0;
                  r_state <= (divisor == '0) ? ZERO : ITER;
               end
            end
            ITER: begin
               // Quotient bits shift into rl as the dividend bits shift out of it.
               r_rh  <= w_rh_nxt;
               r_rl  <= {r_rl[WL-2:0], w_qbit};
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) r_state <= FIX;
            end
            FIX: begin
               r_q     <= w_q_fix;
               r_r     <= w_r_fix;
               r_dbz   <= 1'b0;
               r_ov    <= r_ovf;
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            ZERO: begin
               r_q     <= '1;
               r_r     <= r_dvd;
               r_dbz   <= 1'b1;
               r_ov    <= 1'b0;
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ready       = r_ready;
   assign busy        = ~r_ready;
   assign done        = r_done;
   assign quotient    = r_q;
   assign remainder   = r_r;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ov;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed cases at WL=8, random sweeps at WL=4 and WL=16
// against an arithmetic reference model.
module tb_seq_restoring_divider;

   logic CLK, RST;
   int   total = 0;
   int   bad   = 0;

   logic       st4, sm4, rdy4, bsy4, dn4, dz4, ov4;
   logic [3:0] a4, b4, q4, r4;
   logic       st8, sm8, rdy8, bsy8, dn8, dz8, ov8;
   logic [7:0] a8, b8, q8, r8;
   logic        st16, sm16, rdy16, bsy16, dn16, dz16, ov16;
   logic [15:0] a16, b16, q16, r16;

   seq_restoring_divider #(.WL(4), .SIGNED_EN(1'b1)) u_d4 (
      .CLK(CLK), .RST(RST), .start(st4), .signed_mode(sm4), .dividend(a4), .divisor(b4),
      .ready(rdy4), .busy(bsy4), .done(dn4), .quotient(q4), .remainder(r4),
      .div_by_zero(dz4), .overflow(ov4));

   seq_restoring_divider #(.WL(8), .SIGNED_EN(1'b1)) u_d8 (
      .CLK(CLK), .RST(RST), .start(st8), .signed_mode(sm8), .dividend(a8), .divisor(b8),
      .ready(rdy8), .busy(bsy8), .done(dn8), .quotient(q8), .remainder(r8),
      .div_by_zero(dz8), .overflow(ov8));

   seq_restoring_divider #(.WL(16), .SIGNED_EN(1'b1)) u_d16 (
      .CLK(CLK), .RST(RST), .start(st16), .signed_mode(sm16), .dividend(a16), .divisor(b16),
      .ready(rdy16), .busy(bsy16), .done(dn16), .quotient(q16), .remainder(r16),
      .div_by_zero(dz16), .overflow(ov16));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Truncating-division reference built from plain integer arithmetic.
   task automatic ref_div(input int wl, input bit s, input longint a, input longint b,
                          output longint q, output longint r, output bit dz, output bit ov);
      longint m, half, sa, sb;
      m    = (longint'(1) << wl) - 1;
      half = longint'(1) << (wl - 1);
      dz = 0; ov = 0;
      if (b == 0) begin
         q = m; r = a; dz = 1;
      end else if (s) begin
         sa = (a >= half) ? a - (m + 1) : a;
         sb = (b >= half) ? b - (m + 1) : b;
         if (sa == -half && sb == -1) begin
            q = half; r = 0; ov = 1;
         end else begin
            q = (sa / sb) & m;
            r = (sa % sb) & m;
         end
      end else begin
         q = a / b; r = a % b;
      end
   endtask

   task automatic drive(input int k, input bit go, input bit s, input longint a, input longint b);
      case (k)
         0: begin st4 = go; sm4 = s; a4 = 4'(a); b4 = 4'(b); end
         1: begin st8 = go; sm8 = s; a8 = 8'(a); b8 = 8'(b); end
         default: begin st16 = go; sm16 = s; a16 = 16'(a); b16 = 16'(b); end
      endcase
   endtask

   task automatic peek(input int k, output logic [63:0] q, output logic [63:0] r,
                       output logic dn, output logic rd, output logic bz,
                       output logic dz, output logic ov);
      case (k)
         0: begin q = 64'(q4); r = 64'(r4); dn = dn4; rd = rdy4; bz = bsy4; dz = dz4; ov = ov4; end
         1: begin q = 64'(q8); r = 64'(r8); dn = dn8; rd = rdy8; bz = bsy8; dz = dz8; ov = ov8; end
         default: begin q = 64'(q16); r = 64'(r16); dn = dn16; rd = rdy16; bz = bsy16; dz = dz16; ov = ov16; end
      endcase
   endtask

   task automatic do_op(input int k, input int wl, input bit s, input longint a, input longint b,
                        input string tag);
      longint     eq, er;
      bit         edz, eov;
      logic [63:0] q, r;
      logic       dn, rd, bz, dz, ov;
      int         cyc, lat;
      ref_div(wl, s, a, b, eq, er, edz, eov);
      lat = (b == 0) ? 2 : wl + 2;
      @(negedge CLK);
      drive(k, 1'b1, s, a, b);
      @(posedge CLK);
      #1 drive(k, 1'b0, s, a, b);
      cyc = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         peek(k, q, r, dn, rd, bz, dz, ov);
         if (dn) begin cyc = c; break; end
      end
      chk({tag, " latency"}, 64'(cyc), 64'(lat));
      chk({tag, " quotient"}, q, 64'(eq));
      chk({tag, " remainder"}, r, 64'(er));
      chk({tag, " div_by_zero"}, 64'(dz), 64'(edz));
      chk({tag, " overflow"}, 64'(ov), 64'(eov));
      chk({tag, " busy@done"}, 64'({rd, bz}), 64'(2'b01));
      @(negedge CLK);
      peek(k, q, r, dn, rd, bz, dz, ov);
      chk({tag, " ready after"}, 64'({rd, bz, dn}), 64'(3'b100));
      chk({tag, " held q"}, q, 64'(eq));
   endtask

   initial begin
      int n;
      longint m, a, b;
      bit s;
      RST = 1'b0;
      drive(0, 1'b0, 1'b0, 0, 0);
      drive(1, 1'b0, 1'b0, 0, 0);
      drive(2, 1'b0, 1'b0, 0, 0);
      #12;
      chk("reset ctl8", 64'({rdy8, bsy8, dn8, dz8, ov8}), 64'(5'b10000));
      chk("reset res8", 64'({q8, r8}), 64'(0));
      chk("reset ctl4_16", 64'({rdy4, bsy4, dn4, rdy16, bsy16, dn16}), 64'(6'b100100));
      @(negedge CLK);
      RST = 1'b1;

      do_op(1, 8, 1'b0, 200, 7, "u200/7");
      do_op(1, 8, 1'b1, 8'hF9, 2, "s-7/2");
      do_op(1, 8, 1'b1, 7, 8'hFE, "s7/-2");
      do_op(1, 8, 1'b0, 255, 0, "u255/0");
      do_op(1, 8, 1'b1, 255, 0, "s255/0");
      do_op(1, 8, 1'b1, 8'h80, 8'hFF, "s-128/-1");
      do_op(1, 8, 1'b1, 8'h80, 1, "s-128/1");
      do_op(1, 8, 1'b0, 8'h80, 8'hFF, "u128/255");

      // start held high while busy: only the first request may complete
      @(negedge CLK);
      st8 = 1'b1; sm8 = 1'b0; a8 = 8'd10; b8 = 8'd3;
      @(posedge CLK);
      #1;
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         if (dn8) begin n++; st8 = 1'b0; break; end
         a8 = 8'($urandom); b8 = 8'($urandom) | 8'd1; st8 = 1'b1;
      end
      chk("repulse q", 64'(q8), 64'(3));
      chk("repulse r", 64'(r8), 64'(1));
      repeat (5) begin
         @(negedge CLK);
         if (dn8) n++;
      end
      chk("repulse dones", 64'(n), 64'(1));

      // reset in the middle of an iteration
      @(negedge CLK);
      st8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd7;
      @(posedge CLK);
      #1 st8 = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("midrst ctl", 64'({rdy8, bsy8, dn8, dz8, ov8}), 64'(5'b10000));
      chk("midrst res", 64'({q8, r8}), 64'(0));
      @(negedge CLK);
      RST = 1'b1;
      n = 0;
      repeat (12) begin
         @(negedge CLK);
         if (dn8) n++;
      end
      chk("midrst no done", 64'(n), 64'(0));
      do_op(1, 8, 1'b0, 15, 4, "u15/4");

      // random sweeps at WL=4 and WL=16
      for (int k = 0; k <= 2; k += 2) begin
         int wl;
         wl = (k == 0) ? 4 : 16;
         m  = (longint'(1) << wl) - 1;
         for (int i = 0; i < 50; i++) begin
            s = 1'($urandom_range(0, 1));
            a = longint'($urandom) & m;
            b = longint'($urandom) & m;
            case ($urandom_range(0, 9))
               0: b = 0;
               1: begin a = longint'(1) << (wl - 1); b = m; end
               2: b = (longint'($urandom) & 3) + 1;
               default: ;
            endcase
            do_op(k, wl, s, a, b, (k == 0) ? "rnd4" : "rnd16");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
